// File: rtl/isqrt_sched_pkg.sv
// Shared definitions for the isqrt round-robin scheduler.
//   ISQRT_W_X / ISQRT_W_Y : operand and result widths of the shared isqrt.
//   rr_pick()             : round-robin search over up to RR_MAX requesters.
package isqrt_sched_pkg;

  localparam int ISQRT_W_X = 32;
  localparam int ISQRT_W_Y = 16;
  localparam int RR_MAX    = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Returns the first set bit of vld at or after ptr, wrapping modulo n.
  // ptr is always below n, so a single conditional subtract replaces a modulo.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] vld,
                                       input logic [2:0]        ptr,
                                       input int                n);
    rr_pick_t res;
    int       idx;
    res = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = int'({29'd0, ptr}) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !res.found && vld[idx[2:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/isqrt_rr_scheduler_if.sv
// Requester-side bus of the isqrt scheduler.
//   req_vld / req_x : per-requester request valid and operand (slice i = [32*i+31:32*i])
//   req_rdy         : one-hot grant
//   rsp_vld / rsp_y : one-cycle result pulse per requester and the shared result
// master = requester side, slave = scheduler side.
interface isqrt_rr_scheduler_if #(
  parameter int N_REQ = 2
);
  import isqrt_sched_pkg::*;

  logic [N_REQ-1:0]           req_vld;
  logic [ISQRT_W_X*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]           req_rdy;
  logic [N_REQ-1:0]           rsp_vld;
  logic [ISQRT_W_Y-1:0]       rsp_y;

  modport master (output req_vld, req_x, input req_rdy, rsp_vld, rsp_y);
  modport slave  (input req_vld, req_x, output req_rdy, rsp_vld, rsp_y);

endinterface

// File: rtl/isqrt_tag_pipe.sv
// Tag shift register tracking the requester id of every operation inside isqrt,
// plus a count of valid stages.
//   in_vld / in_id   : tag entering stage 0 (the issue of this cycle)
//   out_vld / out_id : last stage, aligned with the isqrt result valid
//   count            : number of valid stages
module isqrt_tag_pipe #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  input  logic [ID_W-1:0]            in_id,
  output logic                       out_vld,
  output logic [ID_W-1:0]            out_id,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  logic [DEPTH-1:0] vld_p;
  logic [ID_W-1:0]  id_p [DEPTH];

  // Stage 0 .. DEPTH-1: valid bits are control and cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p <= (vld_p << 1) | DEPTH'(in_vld);
    end
  end

  // Ids only matter where the matching valid bit is set.
  always_ff @(posedge clk) begin
    id_p[0] <= in_id;
    for (int i = 1; i < DEPTH; i++) begin
      id_p[i] <= id_p[i-1];
    end
  end

  assign out_vld = vld_p[DEPTH-1];
  assign out_id  = id_p[DEPTH-1];

  // The last stage leaves every cycle, so retire is simply out_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({in_vld, out_vld})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/isqrt_rr_scheduler.sv
// Shares one fully pipelined isqrt between N_REQ requesters.
//   clk, rst_n        : clock, asynchronous active-low reset (shared with isqrt)
//   bus (slave)       : requester handshake and result routing
//   isqrt_x_vld/x     : operand to isqrt
//   isqrt_y_vld/y     : result from isqrt, ISQRT_LATENCY cycles after the operand
//   inflight          : operations currently inside isqrt
//   err               : sticky mismatch between isqrt_y_vld and the tag pipeline
module isqrt_rr_scheduler
  import isqrt_sched_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int ISQRT_LATENCY = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  isqrt_rr_scheduler_if.slave                bus,
  output logic                               isqrt_x_vld,
  output logic [ISQRT_W_X-1:0]               isqrt_x,
  input  logic                               isqrt_y_vld,
  input  logic [ISQRT_W_Y-1:0]               isqrt_y,
  output logic [$clog2(ISQRT_LATENCY+1)-1:0] inflight,
  output logic                               err
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [ID_W-1:0]      ptr;
  rr_pick_t             pick;
  logic [ID_W-1:0]      g;
  logic                 tag_vld;
  logic [ID_W-1:0]      tag_id;
  logic [N_REQ-1:0]     rsp_vld_p0;
  logic [ISQRT_W_Y-1:0] rsp_y_p0;

  assign pick        = rr_pick(8'(bus.req_vld), 3'(ptr), N_REQ);
  assign g           = pick.idx[ID_W-1:0];
  assign isqrt_x_vld = pick.found;
  assign bus.req_rdy = pick.found ? (ONE << g) : '0;

  always_comb begin
    isqrt_x = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick.found && g == ID_W'(i)) begin
        isqrt_x = bus.req_x[i*ISQRT_W_X +: ISQRT_W_X];
      end
    end
  end

  // Issue: the pointer moves just past the winner so it gets lowest priority next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (pick.found) begin
      ptr <= (g == ID_W'(N_REQ-1)) ? '0 : g + 1'b1;
    end
  end

  isqrt_tag_pipe #(
    .DEPTH (ISQRT_LATENCY),
    .ID_W  (ID_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (isqrt_x_vld),
    .in_id   (g),
    .out_vld (tag_vld),
    .out_id  (tag_id),
    .count   (inflight)
  );

  // Response stage p0: only a result matched by a live tag is delivered;
  // a spurious or missing result only raises err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p0 <= '0;
      rsp_y_p0   <= '0;
      err        <= 1'b0;
    end else begin
      rsp_vld_p0 <= '0;
      if (tag_vld && isqrt_y_vld) begin
        rsp_vld_p0 <= ONE << tag_id;
        rsp_y_p0   <= isqrt_y;
      end
      if (tag_vld != isqrt_y_vld) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.rsp_vld = rsp_vld_p0;
  assign bus.rsp_y   = rsp_y_p0;

endmodule

// File: tb/tb_isqrt_rr_scheduler.sv
// Scoreboard bench for isqrt_rr_scheduler with N_REQ=4, ISQRT_LATENCY=4.
// A behavioural isqrt stand-in sits behind the scheduler; a reference model
// predicts grants, operands and inflight, and queues the expected responses
// that a separate monitor pops when rsp_vld is seen.
module tb_isqrt_rr_scheduler;

  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int CW  = $clog2(LAT+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  isqrt_rr_scheduler_if #(.N_REQ(N)) bus ();

  logic          isqrt_x_vld;
  logic [31:0]   isqrt_x;
  logic          isqrt_y_vld;
  logic [15:0]   isqrt_y;
  logic [CW-1:0] inflight;
  logic          err;

  isqrt_rr_scheduler #(.N_REQ(N), .ISQRT_LATENCY(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .isqrt_x_vld (isqrt_x_vld),
    .isqrt_x     (isqrt_x),
    .isqrt_y_vld (isqrt_y_vld),
    .isqrt_y     (isqrt_y),
    .inflight    (inflight),
    .err         (err)
  );

  int  n_chk = 0;
  int  n_err = 0;
  int  n_rsp = 0;
  longint cyc = 0;
  logic inj = 1'b0;
  logic err_exp = 1'b0;

  function automatic longint isqrt_ref(input longint x);
    longint lo, hi, mid;
    lo = 0; hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid; else hi = mid;
    end
    return lo;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural isqrt with the same reset as the scheduler.
  logic [LAT-1:0] mv;
  logic [15:0]    my [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mv <= '0;
    else        mv <= {mv[LAT-2:0], isqrt_x_vld};
  end
  always @(posedge clk) begin
    my[0] <= 16'(isqrt_ref(longint'(isqrt_x)));
    for (int i = 1; i < LAT; i++) my[i] <= my[i-1];
  end
  assign isqrt_y_vld = mv[LAT-1] | inj;
  assign isqrt_y     = my[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     id;
    longint y;
    longint c;
  } exp_t;
  exp_t   sb[$];
  longint iss[$];
  int     mptr = 0;

  // Reference model: grant = first valid requester at or after mptr (mod N).
  always @(negedge clk) begin
    int          g;
    int          idx;
    logic [N-1:0] er;
    longint      xv;
    if (!rst_n) begin
      mptr = 0;
      sb.delete();
      iss.delete();
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && bus.req_vld[idx]) g = idx;
      end
      er = (g < 0) ? '0 : (N'(1) << g);
      xv = (g < 0) ? 0 : longint'(bus.req_x[g*32 +: 32]);
      chk("req_rdy", bus.req_rdy, er);
      chk("isqrt_x_vld", isqrt_x_vld, (g >= 0) ? 1 : 0);
      chk("isqrt_x", isqrt_x, xv);
      while (iss.size() > 0 && iss[0] < cyc - LAT) void'(iss.pop_front());
      chk("inflight", inflight, iss.size());
      chk("err", err, err_exp);
      if (g >= 0) begin
        sb.push_back('{g, isqrt_ref(xv), cyc});
        iss.push_back(cyc);
        mptr = (g + 1) % N;
      end
    end
  end

  // Monitor: every response must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_vld != '0) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", bus.rsp_vld, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_vld", bus.rsp_vld, longint'(1) << e.id);
        chk("rsp_y", bus.rsp_y, e.y);
        chk("rsp_latency", cyc - e.c, LAT + 1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    err_exp = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp(output int lat, output logic [N-1:0] v, output logic [15:0] y);
    lat = 0; v = '0; y = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.rsp_vld != '0) begin
        lat = k; v = bus.rsp_vld; y = bus.rsp_y;
        break;
      end
    end
  endtask

  initial begin
    int           lat;
    logic [N-1:0] v;
    logic [15:0]  y;
    logic [N-1:0] gnt;
    logic [N-1:0] fair_exp [3];
    int           peak;
    int           n0;

    bus.req_vld = '0;
    bus.req_x   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_rsp_vld", bus.rsp_vld, 0);
    chk("reset_rsp_y", bus.rsp_y, 0);
    chk("reset_inflight", inflight, 0);
    chk("reset_err", err, 0);

    // Single request: 144 -> 12 after 5 cycles
    @(posedge clk); #1;
    bus.req_vld = 4'b0001; bus.req_x[31:0] = 32'd144;
    @(negedge clk);
    chk("single_rdy", bus.req_rdy, 4'b0001);
    @(posedge clk); #1;
    bus.req_vld = '0;
    wait_rsp(lat, v, y);
    chk("single_latency", lat, 5);
    chk("single_rsp_vld", v, 4'b0001);
    chk("single_rsp_y", y, 12);
    idle(3);
    do_reset();

    // Two requesters held for 4 cycles: alternate grants, inflight reaches 4
    bus.req_vld = 4'b0011; bus.req_x[31:0] = 32'd16; bus.req_x[63:32] = 32'd81;
    peak = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (int'(inflight) > peak) peak = int'(inflight);
      @(posedge clk); #1;
      if (k == 3) bus.req_vld = '0;
    end
    chk("alt_inflight_peak", peak, 4);
    do_reset();

    // Fairness with requesters 1 and 3 valid
    fair_exp[0] = 4'b0010; fair_exp[1] = 4'b1000; fair_exp[2] = 4'b0010;
    bus.req_vld = 4'b1010;
    bus.req_x[63:32] = 32'd50; bus.req_x[127:96] = 32'd1000000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fair_grant", bus.req_rdy, fair_exp[k]);
      @(posedge clk); #1;
    end
    bus.req_vld = '0;
    idle(8);

    // Full throughput on requester 2, x = 0..19
    n0 = n_rsp;
    for (int k = 0; k < 20; k++) begin
      bus.req_vld = 4'b0100; bus.req_x[95:64] = 32'(k);
      @(posedge clk); #1;
    end
    bus.req_vld = '0;
    idle(8);
    chk("throughput_count", n_rsp - n0, 20);

    // Random traffic; operands only change after a grant
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      gnt = bus.req_rdy;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!bus.req_vld[i] || gnt[i]) begin
          bus.req_vld[i] = ($urandom_range(0, 3) != 0);
          bus.req_x[i*32 +: 32] = ($urandom_range(0, 1) != 0) ? $urandom
                                                              : 32'($urandom_range(0, 1000));
        end
      end
    end
    bus.req_vld = '0;
    idle(10);

    // Spurious result on an empty pipeline
    n0 = n_rsp;
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    err_exp = 1'b1;
    @(negedge clk);
    chk("spurious_err", err, 1);
    idle(6);
    chk("spurious_no_rsp", n_rsp - n0, 0);
    chk("err_sticky", err, 1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", err, 0);

    // Reset while three operations are in flight
    @(posedge clk); #1;
    n0 = n_rsp;
    bus.req_vld = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      bus.req_x[31:0] = 32'(100 + k);
      @(posedge clk); #1;
    end
    bus.req_vld = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(10);
    chk("midreset_no_rsp", n_rsp - n0, 0);
    @(negedge clk);
    chk("midreset_inflight", inflight, 0);
    chk("midreset_err", err, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
